fft_mem_sequencer: RTL and testbench
====================================

Name: fft_mem_sequencer

Overview:
- Address and control sequencer for the FFT working memory (dual-port RAM: one write port, one read port, write on posedge, read data registered on negedge).
- Drives an in-place radix-2 decimation-in-time FFT over N = 2^LOG2_N points, stage by stage.
- Issues one read address per cycle, a twiddle index per butterfly, and write-back addresses delayed by the butterfly pipeline latency.
- Input data is already resident in the RAM in bit-reversed order. This block does not load or unload samples.

Parameters:
- LOG2_N, 4, log2 of FFT size. N = 2^LOG2_N. Legal range 1..12.
- BFLY_LATENCY, 2, cycles from a read address being presented to the matching result being written. Legal range ≥1.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run a full FFT; ignored while busy=1.
- busy  out  1  high while a transform is in progress.
- done  out  1  one-cycle pulse when the last write of the last stage has completed.
- stage  out  LOG2_N-bit-wide counter field sized to hold 0..LOG2_N-1  current stage index.
- rd_addr  out  LOG2_N  RAM read address.
- rd_valid  out  1  rd_addr is a live butterfly operand this cycle.
- rd_sel  out  1  0 = top operand, 1 = bottom operand of the current butterfly.
- tw_addr  out  LOG2_N-1 (min 1)  twiddle ROM index; valid with rd_valid, constant across both operands of a butterfly.
- wr_addr  out  LOG2_N  RAM write address.
- wr_en  out  1  RAM write enable.

Behaviour:
- Reset: all outputs 0. State = IDLE. Stage, butterfly and phase counters = 0. Delay pipeline cleared. Reset takes effect immediately at any point, including mid-transform; wr_en drops asynchronously and the RAM contents are simply left partial.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 at a posedge moves to READ. busy=1 and the first rd_valid appear in the next cycle (cycle 1 if start is sampled at cycle 0).
- READ: runs N consecutive rd_valid cycles per stage, two per butterfly b = 0..N/2-1, top then bottom.
  - span = 2^s, pos = b mod span, group = b >> s.
  - top = group·2^(s+1) + pos, bottom = top + span.
  - tw_addr = pos << (LOG2_N-1-s).
  - After the bottom read of b = N/2-1, go to DRAIN.
- Write pipeline: a shift register of depth BFLY_LATENCY carries {rd_addr, rd_valid}. wr_addr/wr_en equal rd_addr/rd_valid delayed by exactly BFLY_LATENCY cycles, in the same order.
- DRAIN: no reads issued. Stays until the cycle holding the stage's last wr_en.
  - If s < LOG2_N-1: increment stage; the next stage's first rd_valid is in the cycle immediately after that last wr_en.
  - Otherwise go to DONE.
- No read of stage s+1 may coincide with or precede any write of stage s (read-after-write hazard on in-place data).
- Per-stage period: N + BFLY_LATENCY cycles.
- DONE: lasts one cycle. done=1, busy=0, stage returns to 0, then IDLE.
  - With the first read at cycle 1, the final wr_en is at cycle LOG2_N·(N+BFLY_LATENCY) and done is at the cycle after it.
- busy is high from the first rd_valid through the final wr_en, inclusive.
- start asserted in the DONE cycle is ignored. start asserted in IDLE the cycle after done launches a new run.
- Counters wrap cleanly: b and phase reset to 0 at each stage boundary. No address exceeds N-1.

Test Plan:
- Reset mid-READ at stage 2 → all outputs 0 in the same cycle (async); after release, the next start produces stage-0 reads starting at address 0.
- LOG2_N=4, L=2: start at cycle 0 → stage 0 rd_addr = 0,1,2,3,…,15 in cycles 1–16, tw_addr=0 throughout; wr_addr 0..15 in cycles 3–18; stage 1 first read in cycle 19.
- Stage 1 read order → 0,2,1,3,4,6,5,7,8,10,9,11,12,14,13,15; tw_addr per butterfly = 0,4,0,4,0,4,0,4.
- Stage 3 read order → 0,8,1,9,…,7,15; tw_addr per butterfly = 0..7; last wr_en at cycle 72, done=1 at cycle 73 with busy=0.
- start pulsed during busy and again in the DONE cycle → no effect. start in cycle 74 → new run, first read in cycle 75.
- LOG2_N=1, L=1 → single stage: reads 0,1 in cycles 1–2, writes 0,1 in cycles 2–3, done in cycle 4.

Source files
------------

// File: rtl/fft_mem_sequencer.sv
// Read/twiddle/write-back address sequencer for an in-place radix-2 DIT FFT.
// Reads appear the cycle after start; writes trail reads by BFLY_LATENCY; no backpressure, start is ignored while busy.
module fft_mem_sequencer #(
    parameter int LOG2_N       = 4,
    parameter int BFLY_LATENCY = 2,
    localparam int TW          = (LOG2_N > 1) ? LOG2_N - 1 : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LOG2_N-1:0] stage,
    output logic [LOG2_N-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_sel,
    output logic [TW-1:0]     tw_addr,
    output logic [LOG2_N-1:0] wr_addr,
    output logic              wr_en
);

    localparam int AW = LOG2_N;
    localparam int BW = TW;
    localparam int DW = (BFLY_LATENCY > 1) ? $clog2(BFLY_LATENCY) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [BW-1:0] B_LAST     = BW'((1 << (LOG2_N - 1)) - 1);
    localparam logic [AW-1:0] STAGE_LAST = AW'(LOG2_N - 1);
    localparam logic [DW-1:0] D_LAST     = DW'(BFLY_LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] stage_q, stage_d;
    logic [BW-1:0] bfly_q, bfly_d;
    logic          phase_q, phase_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [BFLY_LATENCY-1:0][AW:0] pipe_q, pipe_d;

    logic          rd_live;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] lo_mask;
    logic [AW-1:0] span_bit;
    logic [AW-1:0] top_addr;
    logic [BW-1:0] pos;
    logic [BW-1:0] tw_c;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        phase_d = phase_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (phase_q) begin
                    phase_d = 1'b0;
                    if (bfly_q == B_LAST) begin
                        bfly_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        bfly_d = bfly_q + BW'(1);
                    end
                end else begin
                    phase_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // Leave only once the stage's final write is on the bus, so the next stage never reads stale data.
                if (drain_q == D_LAST) begin
                    drain_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        stage_d = '0;
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + AW'(1);
                        state_d = S_READ;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Top operand index = butterfly index with a zero bit inserted at position stage.
    always_comb begin
        rd_live  = (state_q == S_READ);
        b_ext    = AW'(bfly_q);
        lo_mask  = (AW'(1) << stage_q) - AW'(1);
        span_bit = AW'(1) << stage_q;
        top_addr = ((b_ext & ~lo_mask) << 1) | (b_ext & lo_mask);
        pos      = bfly_q & ((BW'(1) << stage_q) - BW'(1));
        tw_c     = pos << (STAGE_LAST - stage_q);
    end

    always_comb begin
        rd_valid = rd_live;
        rd_sel   = rd_live & phase_q;
        rd_addr  = rd_live ? (phase_q ? (top_addr | span_bit) : top_addr) : '0;
        tw_addr  = rd_live ? tw_c : '0;
        busy     = (state_q == S_READ) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
        stage    = stage_q;
        wr_addr  = pipe_q[BFLY_LATENCY-1][AW:1];
        wr_en    = pipe_q[BFLY_LATENCY-1][0];
    end

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {rd_addr, rd_valid};
        for (int i = 1; i < BFLY_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
            pipe_q  <= pipe_d;
        end
    end

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Bench for fft_mem_sequencer: a 16-point/latency-2 instance and a 2-point/latency-1 instance
// checked every cycle against an arithmetic schedule model, plus literal spot values.
module tb_fft_mem_sequencer;

    logic clk;
    logic rst_n;
    logic start1, start2;

    logic       busy1, done1, rd_valid1, rd_sel1, wr_en1;
    logic [3:0] stage1, rd_addr1, wr_addr1;
    logic [2:0] tw_addr1;

    logic       busy2, done2, rd_valid2, rd_sel2, wr_en2;
    logic [0:0] stage2, rd_addr2, wr_addr2, tw_addr2;

    int cyc;
    int vectors;
    int miscompares;
    int rs1, rs2, base1, base2;

    fft_mem_sequencer #(.LOG2_N(4), .BFLY_LATENCY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .busy(busy1), .done(done1), .stage(stage1),
        .rd_addr(rd_addr1), .rd_valid(rd_valid1), .rd_sel(rd_sel1),
        .tw_addr(tw_addr1), .wr_addr(wr_addr1), .wr_en(wr_en1)
    );

    fft_mem_sequencer #(.LOG2_N(1), .BFLY_LATENCY(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .busy(busy2), .done(done2), .stage(stage2),
        .rd_addr(rd_addr2), .rd_valid(rd_valid2), .rd_sel(rd_sel2),
        .tw_addr(tw_addr2), .wr_addr(wr_addr2), .wr_en(wr_en2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int busy, done, stage, rv, ra, rs, tw, we, wa;
    } exp_t;

    // Operand address of the k-th read of stage s: butterfly k/2, top/bottom by k%2.
    function automatic int op_addr(int s, int k);
        int b, span;
        b    = k / 2;
        span = 1 << s;
        return (b / span) * 2 * span + (b % span) + (k % 2) * span;
    endfunction

    // Expected outputs t cycles after start was accepted (t < 0: idle, no run).
    function automatic exp_t model(int lg, int lat, int t);
        exp_t e;
        int n, per, p, s, k, tw_t;
        e = '{default: 0};
        n   = 1 << lg;
        per = n + lat;
        p   = lg * per;
        if (t >= 1 && t <= p) begin
            e.busy  = 1;
            s       = (t - 1) / per;
            k       = (t - 1) % per;
            e.stage = s;
            if (k < n) begin
                e.rv = 1;
                e.ra = op_addr(s, k);
                e.rs = k % 2;
                e.tw = ((k / 2) % (1 << s)) << (lg - 1 - s);
            end
        end
        tw_t = t - lat;
        if (tw_t >= 1 && tw_t <= p) begin
            s = (tw_t - 1) / per;
            k = (tw_t - 1) % per;
            if (k < n) begin
                e.we = 1;
                e.wa = op_addr(s, k);
            end
        end
        if (t == p + 1) e.done = 1;
        return e;
    endfunction

    function automatic bit model_idle(int lg, int lat, int t);
        return (t < 0) || (t > lg * ((1 << lg) + lat) + 1);
    endfunction

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst1_busy", busy1, 0);      chk("rst1_done", done1, 0);
        chk("rst1_stage", stage1, 0);    chk("rst1_rd_valid", rd_valid1, 0);
        chk("rst1_rd_addr", rd_addr1, 0); chk("rst1_rd_sel", rd_sel1, 0);
        chk("rst1_tw", tw_addr1, 0);     chk("rst1_wr_en", wr_en1, 0);
        chk("rst1_wr_addr", wr_addr1, 0); chk("rst2_busy", busy2, 0);
        chk("rst2_rd_valid", rd_valid2, 0); chk("rst2_wr_en", wr_en2, 0);
        chk("rst2_done", done2, 0);
    endtask

    // Single compare process: model check every cycle, then literal spot checks.
    initial begin
        exp_t e;
        int t1, t2;
        rs1 = -1; rs2 = -1; base1 = -1; base2 = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_all_zero();
                rs1 = -1;
                rs2 = -1;
            end else begin
                t1 = (rs1 < 0) ? -1 : cyc - rs1;
                e = model(4, 2, t1);
                chk("d1_busy", busy1, e.busy);
                chk("d1_done", done1, e.done);
                chk("d1_stage", stage1, e.stage);
                chk("d1_rd_valid", rd_valid1, e.rv);
                chk("d1_wr_en", wr_en1, e.we);
                if (e.rv != 0) begin
                    chk("d1_rd_addr", rd_addr1, e.ra);
                    chk("d1_rd_sel", rd_sel1, e.rs);
                    chk("d1_tw_addr", tw_addr1, e.tw);
                end
                if (e.we != 0) chk("d1_wr_addr", wr_addr1, e.wa);

                t2 = (rs2 < 0) ? -1 : cyc - rs2;
                e = model(1, 1, t2);
                chk("d2_busy", busy2, e.busy);
                chk("d2_done", done2, e.done);
                chk("d2_stage", stage2, e.stage);
                chk("d2_rd_valid", rd_valid2, e.rv);
                chk("d2_wr_en", wr_en2, e.we);
                if (e.rv != 0) begin
                    chk("d2_rd_addr", rd_addr2, e.ra);
                    chk("d2_rd_sel", rd_sel2, e.rs);
                    chk("d2_tw_addr", tw_addr2, e.tw);
                end
                if (e.we != 0) chk("d2_wr_addr", wr_addr2, e.wa);

                if (base1 >= 0) begin
                    case (cyc - base1)
                        1:  begin chk("lit_c1_rv", rd_valid1, 1); chk("lit_c1_ra", rd_addr1, 0); chk("lit_c1_busy", busy1, 1); end
                        3:  begin chk("lit_c3_we", wr_en1, 1); chk("lit_c3_wa", wr_addr1, 0); end
                        16: begin chk("lit_c16_ra", rd_addr1, 15); chk("lit_c16_tw", tw_addr1, 0); end
                        18: chk("lit_c18_wa", wr_addr1, 15);
                        19: begin chk("lit_c19_stage", stage1, 1); chk("lit_c19_rv", rd_valid1, 1); chk("lit_c19_ra", rd_addr1, 0); end
                        20: chk("lit_c20_ra", rd_addr1, 2);
                        21: begin chk("lit_c21_ra", rd_addr1, 1); chk("lit_c21_tw", tw_addr1, 4); end
                        55: begin chk("lit_c55_stage", stage1, 3); chk("lit_c55_ra", rd_addr1, 0); end
                        56: begin chk("lit_c56_ra", rd_addr1, 8); chk("lit_c56_tw", tw_addr1, 0); end
                        69: begin chk("lit_c69_ra", rd_addr1, 7); chk("lit_c69_tw", tw_addr1, 7); end
                        70: begin chk("lit_c70_ra", rd_addr1, 15); chk("lit_c70_sel", rd_sel1, 1); end
                        72: begin chk("lit_c72_we", wr_en1, 1); chk("lit_c72_wa", wr_addr1, 15); chk("lit_c72_busy", busy1, 1); end
                        73: begin chk("lit_c73_done", done1, 1); chk("lit_c73_busy", busy1, 0); chk("lit_c73_stage", stage1, 0); end
                        74: begin chk("lit_c74_busy", busy1, 0); chk("lit_c74_rv", rd_valid1, 0); end
                        75: begin chk("lit_c75_rv", rd_valid1, 1); chk("lit_c75_ra", rd_addr1, 0); end
                        default: ;
                    endcase
                end
                if (base2 >= 0) begin
                    case (cyc - base2)
                        1: begin chk("lit2_c1_rv", rd_valid2, 1); chk("lit2_c1_ra", rd_addr2, 0); end
                        2: begin chk("lit2_c2_ra", rd_addr2, 1); chk("lit2_c2_we", wr_en2, 1); chk("lit2_c2_wa", wr_addr2, 0); end
                        3: begin chk("lit2_c3_we", wr_en2, 1); chk("lit2_c3_wa", wr_addr2, 1); chk("lit2_c3_rv", rd_valid2, 0); end
                        4: begin chk("lit2_c4_done", done2, 1); chk("lit2_c4_busy", busy2, 0); end
                        default: ;
                    endcase
                end

                if (start1 && model_idle(4, 2, t1)) begin
                    rs1 = cyc;
                    if (base1 < 0) base1 = cyc;
                end
                if (start2 && model_idle(1, 1, t2)) begin
                    rs2 = cyc;
                    if (base2 < 0) base2 = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        // r counts cycles from the first start; drives land 1 time unit after each posedge.
        for (int r = 0; r < 210; r++) begin
            start1 = (r == 0) || (r == 30) || (r == 73) || (r == 74) || (r == 122);
            start2 = (r == 120);
            if (r == 115) begin
                // Second run is mid-READ in stage 2 with a write in flight; reset must clear outputs at once.
                #1;
                chk("pre_rst_wr_en", wr_en1, 1);
                chk("pre_rst_stage", stage1, 2);
                #1;
                rst_n = 1'b0;
                #1;
                chk_all_zero();
            end
            if (r == 117) rst_n = 1'b1;
            tick();
        end
        start1 = 1'b0;
        start2 = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
